// File: rtl/pdm_rec_pkg.sv
// Shared types and constants for the PDM recording controller.
package pdm_rec_pkg;

    localparam int SAMPLE_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WARMUP  = 2'd1,
        CAPTURE = 2'd2,
        FLUSH   = 2'd3
    } rec_state_t;

endpackage

// File: rtl/pdm_record_ctrl_rise_detect.sv
// One-bit rising-edge detector: rise is high while d=1 and the previous
// registered sample was 0. The registered copy updates every cycle.
module rise_detect (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic d_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/pdm_record_ctrl.sv
// Recording-session sequencer: runs the mic through a warm-up period, then
// stores each Deserializer word into the sample RAM until stop or RAM full.
module pdm_record_ctrl #(
    parameter int ADDR_W        = 14,
    parameter int WARMUP_CYCLES = 1000000,
    parameter int SAMPLE_W      = pdm_rec_pkg::SAMPLE_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    output logic                des_enable_o,
    input  logic                des_done_i,
    input  logic [SAMPLE_W-1:0] des_data_i,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [SAMPLE_W-1:0] mem_wdata_o,
    output logic                busy_o,
    output logic                rec_done_o,
    output logic [ADDR_W:0]     words_o
);

    import pdm_rec_pkg::*;

    localparam int WARM_W = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
    localparam logic [WARM_W-1:0] WARM_LOAD = WARM_W'(WARMUP_CYCLES - 1);
    localparam logic [ADDR_W:0] DEPTH_V = {1'b1, {ADDR_W{1'b0}}};

    rec_state_t state, state_n;
    logic [WARM_W-1:0]   warm, warm_n;
    logic [ADDR_W:0]     count, count_n, count_inc;
    logic                enable, enable_n;
    logic                we, we_n;
    logic [ADDR_W-1:0]   addr, addr_n;
    logic [SAMPLE_W-1:0] wdata, wdata_n;
    logic                done, done_n;
    logic                rise;

    // des_done_i carries no handshake back: a word is taken only on the
    // 0->1 transition, so a held-high level yields exactly one write.
    rise_detect u_rise (
        .clock (clock),
        .reset (reset),
        .d     (des_done_i),
        .rise  (rise)
    );

    assign count_inc = count + 1'b1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            warm   <= '0;
            count  <= '0;
            enable <= 1'b0;
            we     <= 1'b0;
            addr   <= '0;
            wdata  <= '0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            warm   <= warm_n;
            count  <= count_n;
            enable <= enable_n;
            we     <= we_n;
            addr   <= addr_n;
            wdata  <= wdata_n;
            done   <= done_n;
        end
    end

    always_comb begin
        state_n  = state;
        warm_n   = warm;
        count_n  = count;
        enable_n = enable;
        we_n     = 1'b0;
        addr_n   = addr;
        wdata_n  = wdata;
        done_n   = done;

        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n  = WARMUP;
                    enable_n = 1'b1;
                    warm_n   = WARM_LOAD;
                    count_n  = '0;
                    done_n   = 1'b0;
                end
            end
            WARMUP: begin
                if (stop) begin
                    state_n  = IDLE;
                    enable_n = 1'b0;
                    done_n   = 1'b1;
                end else if (warm == '0) begin
                    state_n = CAPTURE;
                end else begin
                    warm_n = warm - 1'b1;
                end
            end
            CAPTURE: begin
                if (rise) begin
                    we_n    = 1'b1;
                    addr_n  = count[ADDR_W-1:0];
                    wdata_n = des_data_i;
                    count_n = count_inc;
                end
                // The write that fills the last address ends the session.
                if (stop || (rise && (count_inc == DEPTH_V))) begin
                    state_n  = FLUSH;
                    enable_n = 1'b0;
                end
            end
            FLUSH: begin
                state_n = IDLE;
                done_n  = 1'b1;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign des_enable_o = enable;
    assign mem_we_o     = we;
    assign mem_addr_o   = addr;
    assign mem_wdata_o  = wdata;
    assign busy_o       = (state != IDLE);
    assign rec_done_o   = done;
    assign words_o      = count;

endmodule

// File: tb/tb_pdm_record_ctrl.sv
// Directed bench for pdm_record_ctrl with ADDR_W=3, WARMUP_CYCLES=20.
module tb_pdm_record_ctrl;

    localparam int ADDR_W = 3;
    localparam int WARMUP = 20;

    logic        clock;
    logic        reset;
    logic        start;
    logic        stop;
    logic        des_enable_o;
    logic        des_done_i;
    logic [15:0] des_data_i;
    logic        mem_we_o;
    logic [2:0]  mem_addr_o;
    logic [15:0] mem_wdata_o;
    logic        busy_o;
    logic        rec_done_o;
    logic [3:0]  words_o;

    int n_tests = 0;
    int n_fail  = 0;
    int wr_cnt  = 0;
    logic [18:0] exp_q[$];

    pdm_record_ctrl #(
        .ADDR_W        (ADDR_W),
        .WARMUP_CYCLES (WARMUP),
        .SAMPLE_W      (16)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .stop         (stop),
        .des_enable_o (des_enable_o),
        .des_done_i   (des_done_i),
        .des_data_i   (des_data_i),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .busy_o       (busy_o),
        .rec_done_o   (rec_done_o),
        .words_o      (words_o)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every observed write must match the next expected one.
    always @(negedge clock) begin
        if (mem_we_o) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", {13'd0, mem_addr_o, mem_wdata_o}, 32'h7FFFF);
            end else begin
                check("write_addr_data", {13'd0, mem_addr_o, mem_wdata_o}, {13'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic gap(input int n);
        des_done_i = 1'b0;
        tick();
        check("we_width", mem_we_o, 0);
        repeat (n - 1) tick();
    endtask

    task automatic send_word(input logic [15:0] data, input logic [2:0] addr, input logic with_stop);
        exp_q.push_back({addr, data});
        des_done_i = 1'b1;
        des_data_i = data;
        stop       = with_stop;
        tick();
        stop = 1'b0;
        check("we_after_rise", mem_we_o, 1);
        des_done_i = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_enable", des_enable_o, 1);
        check("start_busy", busy_o, 1);
        check("start_done_clr", rec_done_o, 0);
        check("start_words_clr", words_o, 0);
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        stop       = 1'b0;
        des_done_i = 1'b0;
        des_data_i = 16'h0;
        tick();
        tick();
        check("rst_enable", des_enable_o, 0);
        check("rst_we", mem_we_o, 0);
        check("rst_addr", mem_addr_o, 0);
        check("rst_wdata", mem_wdata_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", rec_done_o, 0);
        check("rst_words", words_o, 0);
        reset = 1'b0;
        tick();

        // Session 1: warm-up with a discarded pulse, then run to full.
        do_start();
        gap(4);
        des_done_i = 1'b1;
        des_data_i = 16'hDEAD;
        tick();
        check("warmup_discard", mem_we_o, 0);
        gap(15);
        check("warmup_busy", busy_o, 1);
        check("warmup_no_writes", wr_cnt, 0);
        for (int i = 0; i < 8; i++) begin
            send_word(16'h0100 + 16'(i), 3'(i), 1'b0);
            check("full_words", words_o, i + 1);
            if (i < 7) gap(15);
        end
        check("full_flush_enable", des_enable_o, 0);
        check("full_flush_busy", busy_o, 1);
        gap(1);
        check("full_idle_busy", busy_o, 0);
        check("full_rec_done", rec_done_o, 1);
        check("full_words_hold", words_o, 8);
        des_done_i = 1'b1;
        tick();
        check("idle_no_write", mem_we_o, 0);
        gap(3);
        check("full_write_count", wr_cnt, 8);

        // Session 2: stop coincides with the 4th rise.
        do_start();
        gap(20);
        for (int i = 0; i < 3; i++) begin
            send_word(16'h0200 + 16'(i), 3'(i), 1'b0);
            gap(15);
        end
        send_word(16'h0203, 3'd3, 1'b1);
        check("stop_words", words_o, 4);
        check("stop_flush_enable", des_enable_o, 0);
        gap(1);
        check("stop_idle", busy_o, 0);
        check("stop_rec_done", rec_done_o, 1);
        check("stop_words_hold", words_o, 4);

        // Session 3: stop during warm-up.
        do_start();
        gap(9);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("wstop_idle", busy_o, 0);
        check("wstop_enable", des_enable_o, 0);
        check("wstop_rec_done", rec_done_o, 1);
        check("wstop_words", words_o, 0);
        check("wstop_write_count", wr_cnt, 12);

        // Session 4: held-high done gives one write; start in CAPTURE ignored.
        do_start();
        gap(20);
        exp_q.push_back({3'd0, 16'h0300});
        des_done_i = 1'b1;
        des_data_i = 16'h0300;
        tick();
        check("held_first_we", mem_we_o, 1);
        for (int i = 1; i < 40; i++) begin
            start = (i == 10);
            tick();
            check("held_no_rewrite", mem_we_o, 0);
        end
        start = 1'b0;
        check("held_busy", busy_o, 1);
        check("held_words", words_o, 1);
        des_done_i = 1'b0;
        tick();
        send_word(16'h0301, 3'd1, 1'b0);
        check("held_words_next", words_o, 2);
        gap(2);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("held_flush_enable", des_enable_o, 0);
        tick();
        check("held_idle", busy_o, 0);
        check("held_rec_done", rec_done_o, 1);

        // Session 5: reset lands between a rise and its write.
        do_start();
        gap(20);
        send_word(16'h0400, 3'd0, 1'b0);
        gap(15);
        des_done_i = 1'b1;
        des_data_i = 16'h04AA;
        #4;
        reset = 1'b1;
        #1;
        check("mid_rst_enable", des_enable_o, 0);
        check("mid_rst_we", mem_we_o, 0);
        check("mid_rst_busy", busy_o, 0);
        check("mid_rst_words", words_o, 0);
        check("mid_rst_addr", mem_addr_o, 0);
        check("mid_rst_wdata", mem_wdata_o, 0);
        tick();
        reset      = 1'b0;
        des_done_i = 1'b0;
        tick();
        check("mid_rst_write_count", wr_cnt, 15);
        do_start();
        gap(20);
        send_word(16'h0500, 3'd0, 1'b0);
        check("post_rst_words", words_o, 1);
        gap(2);

        check("total_write_count", wr_cnt, 16);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
